// File: rtl/exe_stage.sv
// exe_stage: MIPS EXE stage with operand forwarding, ALU, a 32-cycle shift-add multiplier and the EXE/MEM register.
// Defining EXE_OVF_TRAP_EN enables the ADD/SUB signed-overflow trap (suppressed write-back plus sticky ovf).
module exe_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_regw,
    input  logic        ex_regw_src,
    input  logic        ex_memw,
    input  logic        ex_memw_src,
    input  logic [1:0]  ex_alua_src,
    input  logic [1:0]  ex_alub_src,
    input  logic [3:0]  ex_aluctrl,
    input  logic [4:0]  ex_wbdst,
    input  logic [5:0]  ex_instr_op,
    input  logic [31:0] ex_rega,
    input  logic [31:0] ex_regb,
    input  logic [31:0] ex_imm32,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        mem_regw,
    output logic        mem_regw_src,
    output logic        mem_memw,
    output logic [4:0]  mem_wbdst,
    output logic [5:0]  mem_instr_op,
    output logic [31:0] mem_alu_c,
    output logic [31:0] mem_store_data,
    output logic        ovf
);

    localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      mul_a_r;
    logic [31:0]      mul_b_r;
    logic [31:0]      acc_r;
    logic [31:0]      acc_next_s;
    logic [31:0]      alu_a_s;
    logic [31:0]      alu_b_s;
    logic [31:0]      alu_c_s;
    logic [31:0]      sum_s;
    logic [31:0]      diff_s;
    logic [31:0]      store_data_s;
    logic             trap_s;

    // Operand selection, including both forwarding paths
    always_comb begin
        alu_a_s = ex_rega;
        alu_b_s = ex_regb;
        case (ex_alua_src)
            2'b01:   alu_a_s = mem_alu_c;
            2'b10:   alu_a_s = wb_data;
            default: alu_a_s = ex_rega;
        endcase
        case (ex_alub_src)
            2'b01:   alu_b_s = ex_imm32;
            2'b10:   alu_b_s = mem_alu_c;
            2'b11:   alu_b_s = wb_data;
            default: alu_b_s = ex_regb;
        endcase
    end

    assign sum_s        = alu_a_s + alu_b_s;
    assign diff_s       = alu_a_s - alu_b_s;
    assign store_data_s = ex_memw_src ? wb_data : ex_regb;
    assign acc_next_s   = mul_b_r[0] ? (acc_r + mul_a_r) : acc_r;
    assign stall        = (ex_aluctrl == OP_MUL) && (state_r != ST_DONE);

    // Single-cycle ALU; MUL and unused codes yield 0 here
    always_comb begin
        alu_c_s = 32'd0;
        case (ex_aluctrl)
            OP_ADD:  alu_c_s = sum_s;
            OP_SUB:  alu_c_s = diff_s;
            OP_AND:  alu_c_s = alu_a_s & alu_b_s;
            OP_OR:   alu_c_s = alu_a_s | alu_b_s;
            OP_XOR:  alu_c_s = alu_a_s ^ alu_b_s;
            OP_NOR:  alu_c_s = ~(alu_a_s | alu_b_s);
            OP_SLT:  alu_c_s = ($signed(alu_a_s) < $signed(alu_b_s)) ? 32'd1 : 32'd0;
            OP_SLTU: alu_c_s = (alu_a_s < alu_b_s) ? 32'd1 : 32'd0;
            OP_SLL:  alu_c_s = alu_a_s << alu_b_s[4:0];
            OP_SRL:  alu_c_s = alu_a_s >> alu_b_s[4:0];
            OP_SRA:  alu_c_s = $signed(alu_a_s) >>> alu_b_s[4:0];
            OP_LUI:  alu_c_s = {alu_b_s[15:0], 16'h0000};
            default: alu_c_s = 32'd0;
        endcase
    end

`ifdef EXE_OVF_TRAP_EN
    logic ovf_r;

    function automatic logic add_sub_ovf(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] r, input logic is_sub);
        logic b_sign;
        b_sign = is_sub ? ~b[31] : b[31];
        return (a[31] == b_sign) && (r[31] != a[31]);
    endfunction

    assign trap_s = (ex_aluctrl == OP_ADD) ? add_sub_ovf(alu_a_s, alu_b_s, sum_s, 1'b0) :
                    (ex_aluctrl == OP_SUB) ? add_sub_ovf(alu_a_s, alu_b_s, diff_s, 1'b1) : 1'b0;

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && trap_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`else
    assign trap_s = 1'b0;
    assign ovf    = 1'b0;
`endif

    // Multiplier FSM and EXE/MEM pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            count_r        <= '0;
            mul_a_r        <= 32'd0;
            mul_b_r        <= 32'd0;
            acc_r          <= 32'd0;
            mem_regw       <= 1'b0;
            mem_regw_src   <= 1'b0;
            mem_memw       <= 1'b0;
            mem_wbdst      <= 5'd0;
            mem_instr_op   <= 6'd0;
            mem_alu_c      <= 32'd0;
            mem_store_data <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ex_aluctrl == OP_MUL) begin
                        // Operands are frozen here; later forwarding changes are ignored
                        mul_a_r  <= alu_a_s;
                        mul_b_r  <= alu_b_s;
                        acc_r    <= 32'd0;
                        count_r  <= '0;
                        state_r  <= ST_BUSY;
                        mem_regw <= 1'b0;
                        mem_memw <= 1'b0;
                    end else begin
                        mem_regw       <= ex_regw & ~trap_s;
                        mem_regw_src   <= ex_regw_src;
                        mem_memw       <= ex_memw;
                        mem_wbdst      <= ex_wbdst;
                        mem_instr_op   <= ex_instr_op;
                        mem_alu_c      <= alu_c_s;
                        mem_store_data <= store_data_s;
                    end
                end
                ST_BUSY: begin
                    acc_r    <= acc_next_s;
                    mul_a_r  <= mul_a_r << 1;
                    mul_b_r  <= mul_b_r >> 1;
                    count_r  <= count_r + CNT_W'(1);
                    mem_regw <= 1'b0;
                    mem_memw <= 1'b0;
                    if (count_r == CNT_LAST) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    mem_regw       <= ex_regw;
                    mem_regw_src   <= ex_regw_src;
                    mem_memw       <= ex_memw;
                    mem_wbdst      <= ex_wbdst;
                    mem_instr_op   <= ex_instr_op;
                    mem_alu_c      <= acc_r;
                    mem_store_data <= store_data_s;
                    state_r        <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed and randomized checks of exe_stage against an arithmetic reference model.
// Expectations follow EXE_OVF_TRAP_EN when it is defined for the build.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_regw, ex_regw_src, ex_memw, ex_memw_src;
    logic [1:0]  ex_alua_src, ex_alub_src;
    logic [3:0]  ex_aluctrl;
    logic [4:0]  ex_wbdst;
    logic [5:0]  ex_instr_op;
    logic [31:0] ex_rega, ex_regb, ex_imm32, wb_data;
    logic        stall, mem_regw, mem_regw_src, mem_memw, ovf;
    logic [4:0]  mem_wbdst;
    logic [5:0]  mem_instr_op;
    logic [31:0] mem_alu_c, mem_store_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_alu_c = 32'd0;
    logic        m_ovf   = 1'b0;

    exe_stage dut (
        .clk(clk), .rst(rst),
        .ex_regw(ex_regw), .ex_regw_src(ex_regw_src), .ex_memw(ex_memw), .ex_memw_src(ex_memw_src),
        .ex_alua_src(ex_alua_src), .ex_alub_src(ex_alub_src), .ex_aluctrl(ex_aluctrl),
        .ex_wbdst(ex_wbdst), .ex_instr_op(ex_instr_op),
        .ex_rega(ex_rega), .ex_regb(ex_regb), .ex_imm32(ex_imm32), .wb_data(wb_data),
        .stall(stall), .mem_regw(mem_regw), .mem_regw_src(mem_regw_src), .mem_memw(mem_memw),
        .mem_wbdst(mem_wbdst), .mem_instr_op(mem_instr_op), .mem_alu_c(mem_alu_c),
        .mem_store_data(mem_store_data), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel_a(input logic [1:0] s, input logic [31:0] ra, input logic [31:0] prev,
                                          input logic [31:0] wb);
        if (s == 2'd1) return prev;
        if (s == 2'd2) return wb;
        return ra;
    endfunction

    function automatic logic [31:0] sel_b(input logic [1:0] s, input logic [31:0] rb, input logic [31:0] im,
                                          input logic [31:0] prev, input logic [31:0] wb);
        if (s == 2'd0) return rb;
        if (s == 2'd1) return im;
        if (s == 2'd2) return prev;
        return wb;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        int          sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            4'd7:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd8:  return a << sh;
            4'd9:  return a >> sh;
            4'd10: begin ext = {{32{a[31]}}, a}; ext = ext >> sh; return ext[31:0]; end
            4'd11: return b * 32'd65536;
            4'd12: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint r;
        if (op == 4'd0)      r = longint'($signed(a)) + longint'($signed(b));
        else if (op == 4'd1) r = longint'($signed(a)) - longint'($signed(b));
        else                 return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // flags = {regw, regw_src, memw, memw_src}
    task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [1:0] as, input logic [1:0] bs,
                          input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] im,
                          input logic [31:0] wb, input logic [4:0] dst, input logic [5:0] opc,
                          input logic [3:0] flags);
        logic [31:0] a, b, exp_c;
        logic        exp_regw;
        int          cnt;
        ex_aluctrl = ctrl; ex_alua_src = as; ex_alub_src = bs;
        ex_rega = ra; ex_regb = rb; ex_imm32 = im; wb_data = wb;
        ex_wbdst = dst; ex_instr_op = opc;
        {ex_regw, ex_regw_src, ex_memw, ex_memw_src} = flags;
        a = sel_a(as, ra, m_alu_c, wb);
        b = sel_b(bs, rb, im, m_alu_c, wb);
        exp_c = ref_alu(ctrl, a, b);
        exp_regw = flags[3];
        #1;
        if (ctrl != 4'd12) begin
            check({tag, ":stall"}, {31'd0, stall}, 32'd0);
`ifdef EXE_OVF_TRAP_EN
            if (ref_ovf(ctrl, a, b)) begin
                exp_regw = 1'b0;
                m_ovf    = 1'b1;
            end
`endif
            @(posedge clk); #1;
        end else begin
            cnt = 0;
            while (stall === 1'b1 && cnt < 40) begin
                @(posedge clk); #1;
                cnt++;
                wb_data = $urandom;
                check({tag, ":bubble_regw"}, {31'd0, mem_regw}, 32'd0);
                check({tag, ":bubble_memw"}, {31'd0, mem_memw}, 32'd0);
                check({tag, ":bubble_hold"}, mem_alu_c, m_alu_c);
            end
            check({tag, ":stall_cycles"}, cnt, 32'd33);
            @(posedge clk); #1;
        end
        m_alu_c = exp_c;
        check({tag, ":alu_c"}, mem_alu_c, m_alu_c);
        check({tag, ":regw"}, {31'd0, mem_regw}, {31'd0, exp_regw});
        check({tag, ":regw_src"}, {31'd0, mem_regw_src}, {31'd0, flags[2]});
        check({tag, ":memw"}, {31'd0, mem_memw}, {31'd0, flags[1]});
        check({tag, ":wbdst"}, {27'd0, mem_wbdst}, {27'd0, dst});
        check({tag, ":instr_op"}, {26'd0, mem_instr_op}, {26'd0, opc});
        check({tag, ":store"}, mem_store_data, flags[0] ? wb_data : rb);
        check({tag, ":ovf"}, {31'd0, ovf}, {31'd0, m_ovf});
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ":alu_c"}, mem_alu_c, 32'd0);
        check({tag, ":ctrl"}, {28'd0, mem_regw, mem_regw_src, mem_memw, ovf}, 32'd0);
        check({tag, ":wbdst_op"}, {21'd0, mem_wbdst, mem_instr_op}, 32'd0);
        check({tag, ":store"}, mem_store_data, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        {ex_regw, ex_regw_src, ex_memw, ex_memw_src} = 4'd0;
        ex_alua_src = 2'd0; ex_alub_src = 2'd0; ex_aluctrl = 4'd0;
        ex_wbdst = 5'd0; ex_instr_op = 6'd0;
        ex_rega = 32'd0; ex_regb = 32'd0; ex_imm32 = 32'd0; wb_data = 32'd0;
        #12;
        check_cleared("reset");
        check("reset:stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add_imm", 4'd0, 2'b00, 2'b01, 32'd5, 32'd9, 32'd3, 32'd0, 5'd3, 6'd8, 4'b1000);
        check("add_imm:const", mem_alu_c, 32'd8);
        run_op("sub_fwd", 4'd1, 2'b01, 2'b11, 32'd77, 32'd55, 32'd0, 32'd2, 5'd4, 6'd0, 4'b1001);
        check("sub_fwd:const", mem_alu_c, 32'd6);
        run_op("slt", 4'd6, 2'b00, 2'b01, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 5'd5, 6'd10, 4'b1000);
        check("slt:const", mem_alu_c, 32'd1);
        run_op("sltu", 4'd7, 2'b00, 2'b01, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 5'd6, 6'd11, 4'b1000);
        check("sltu:const", mem_alu_c, 32'd0);
        run_op("sra", 4'd10, 2'b00, 2'b00, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd7, 6'd0, 4'b1000);
        check("sra:const", mem_alu_c, 32'hF800_0000);
        run_op("sll", 4'd8, 2'b00, 2'b00, 32'h0000_0003, 32'h25, 32'd0, 32'd0, 5'd8, 6'd0, 4'b1000);
        check("sll:const", mem_alu_c, 32'h0000_0060);
        run_op("mul7x6", 4'd12, 2'b00, 2'b00, 32'd7, 32'd6, 32'd0, 32'd1, 5'd9, 6'd28, 4'b1100);
        check("mul7x6:const", mem_alu_c, 32'd42);
        run_op("mul_neg", 4'd12, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 5'd10, 6'd28, 4'b1000);
        check("mul_neg:const", mem_alu_c, 32'hFFFF_FFFE);
        run_op("add_ovf", 4'd0, 2'b00, 2'b01, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'd0, 5'd11, 6'd8, 4'b1000);
        check("add_ovf:const", mem_alu_c, 32'h8000_0000);
`ifdef EXE_OVF_TRAP_EN
        check("add_ovf:ovf_on", {31'd0, ovf}, 32'd1);
`else
        check("add_ovf:ovf_off", {31'd0, ovf}, 32'd0);
`endif
        run_op("after_ovf", 4'd0, 2'b00, 2'b01, 32'd1, 32'd0, 32'd1, 32'd0, 5'd12, 6'd8, 4'b1000);

        // Abort a multiply at iteration 10 with an asynchronous reset
        ex_aluctrl = 4'd12; ex_alua_src = 2'b00; ex_alub_src = 2'b00;
        ex_rega = 32'd123; ex_regb = 32'd456; ex_regw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check_cleared("mid_mul_rst");
        ex_aluctrl = 4'd0;
        #1;
        check("mid_mul_rst:stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        m_alu_c = 32'd0;
        m_ovf   = 1'b0;
        run_op("post_rst", 4'd0, 2'b00, 2'b01, 32'd10, 32'd0, 32'd20, 32'd0, 5'd1, 6'd8, 4'b1000);

        for (int i = 0; i < 150; i++) begin
            run_op("rand", 4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), $urandom, $urandom,
                   $urandom, $urandom, 5'($urandom), 6'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
